// File: rtl/multidigit_calculator_fsm.sv
// Keypad calculator controller.
// Takes multi-digit decimal operands from keypad scan codes and applies
// operators strictly left to right, so "2 + 3 * 4 =" gives 20. Results are
// signed two's complement. Division uses an iterative restoring divider.
// Overflow and divide-by-zero enter a sticky error state that only Clear
// can leave.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   key_valid    one-cycle strobe qualifying key_code
//   key_code     8-bit keypad scan code
//   operand      operand being entered (unsigned, zero-extended)
//   result       signed result, either final or intermediate
//   result_valid high while a final result is shown (DONE)
//   busy         high while computing (EXEC or DIV)
//   error        high while in the error state (result forced to 0)
//   key_dropped  one-cycle pulse for a non-Clear key that arrived while busy
module multidigit_calculator_fsm #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [7:0]       key_code,
    output logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             error,
    output logic             key_dropped
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int NW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    COUNT_MAX = CW'(MAX_DIGITS);
    localparam logic [NW-1:0]    DIV_LAST  = NW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] TEN       = WIDTH'(10);

    typedef enum logic [2:0] {S_A, S_B, S_EXEC, S_DIV, S_DONE, S_ERR} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    state_t           state, state_next;
    op_t              op, op_next, pend_op, pend_op_next;
    logic             chain, chain_next;
    logic [WIDTH-1:0] acc, acc_next;
    logic [CW-1:0]    count, count_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             dropped, dropped_next;
    logic [WIDTH-1:0] div_rem, div_rem_next, div_quo, div_quo_next, div_den, div_den_next;
    logic [NW-1:0]    div_cnt, div_cnt_next;
    logic             div_neg, div_neg_next;

    // Key decode
    logic       is_clear, is_digit, is_op, is_eq;
    logic [3:0] digit;
    op_t        key_op;

    always_comb begin
        is_clear = 1'b0;
        is_digit = 1'b0;
        is_op    = 1'b0;
        is_eq    = 1'b0;
        digit    = 4'd0;
        key_op   = OP_ADD;
        if (key_valid) begin
            case (key_code)
                8'h04: is_clear = 1'b1;
                8'h14: begin is_digit = 1'b1; digit = 4'd0; end
                8'h05: begin is_digit = 1'b1; digit = 4'd1; end
                8'h15: begin is_digit = 1'b1; digit = 4'd2; end
                8'h25: begin is_digit = 1'b1; digit = 4'd3; end
                8'h06: begin is_digit = 1'b1; digit = 4'd4; end
                8'h16: begin is_digit = 1'b1; digit = 4'd5; end
                8'h26: begin is_digit = 1'b1; digit = 4'd6; end
                8'h07: begin is_digit = 1'b1; digit = 4'd7; end
                8'h17: begin is_digit = 1'b1; digit = 4'd8; end
                8'h27: begin is_digit = 1'b1; digit = 4'd9; end
                8'h37: begin is_op = 1'b1; key_op = OP_ADD; end
                8'h36: begin is_op = 1'b1; key_op = OP_SUB; end
                8'h35: begin is_op = 1'b1; key_op = OP_MUL; end
                8'h34: begin is_op = 1'b1; key_op = OP_DIV; end
                8'h24: is_eq = 1'b1;
                default: ;
            endcase
        end
    end

    // Digit accumulation; MAX_DIGITS guarantees acc*10+d cannot wrap.
    logic [WIDTH-1:0] acc_accum;
    logic             can_accum;
    assign acc_accum = acc * TEN + WIDTH'(digit);
    assign can_accum = (count < COUNT_MAX);

    // Add/sub/mul evaluated at double width; A is signed, the typed B is not.
    logic [2*WIDTH-1:0] a_wide, b_wide, wide;
    logic               wide_fits;
    assign a_wide = {{WIDTH{a_reg[WIDTH-1]}}, a_reg};
    assign b_wide = {{WIDTH{1'b0}}, acc};

    always_comb begin
        case (op)
            OP_ADD:  wide = a_wide + b_wide;
            OP_SUB:  wide = a_wide - b_wide;
            OP_MUL:  wide = a_wide * b_wide;
            default: wide = '0;
        endcase
    end

    // In range exactly when the top WIDTH+1 bits are all copies of the sign.
    assign wide_fits = (&wide[2*WIDTH-1:WIDTH-1]) || (~|wide[2*WIDTH-1:WIDTH-1]);

    // One restoring-division step: shift in the next dividend bit, try a subtract.
    logic [WIDTH:0]   div_shift, div_trial;
    logic             div_qbit;
    logic [WIDTH-1:0] div_rem_step, div_quo_step, div_value, a_mag;
    assign div_shift    = {div_rem, div_quo[WIDTH-1]};
    assign div_trial    = div_shift - {1'b0, div_den};
    assign div_qbit     = ~div_trial[WIDTH];
    assign div_rem_step = div_qbit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo_step = {div_quo[WIDTH-2:0], div_qbit};
    assign div_value    = div_neg ? -div_quo_step : div_quo_step;
    // -2^(WIDTH-1) maps to 2^(WIDTH-1), still representable as unsigned.
    assign a_mag        = a_reg[WIDTH-1] ? -a_reg : a_reg;

    logic             complete;
    logic [WIDTH-1:0] complete_value;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves one unassigned, which would infer a latch.
        state_next     = state;
        op_next        = op;
        pend_op_next   = pend_op;
        chain_next     = chain;
        acc_next       = acc;
        count_next     = count;
        a_next         = a_reg;
        result_next    = result_reg;
        div_rem_next   = div_rem;
        div_quo_next   = div_quo;
        div_den_next   = div_den;
        div_cnt_next   = div_cnt;
        div_neg_next   = div_neg;
        complete       = 1'b0;
        complete_value = '0;
        dropped_next   = key_valid && !is_clear && (state == S_EXEC || state == S_DIV);

        case (state)
            S_A: begin
                if (is_digit) begin
                    if (can_accum) begin
                        acc_next   = acc_accum;
                        count_next = count + CW'(1);
                    end
                end else if (is_op) begin
                    a_next     = acc;
                    op_next    = key_op;
                    acc_next   = '0;
                    count_next = '0;
                    state_next = S_B;
                end
            end
            S_B: begin
                if (is_digit) begin
                    if (can_accum) begin
                        acc_next   = acc_accum;
                        count_next = count + CW'(1);
                    end
                end else if (is_op) begin
                    if (count == '0) begin
                        op_next = key_op;
                    end else begin
                        pend_op_next = key_op;
                        chain_next   = 1'b1;
                        state_next   = S_EXEC;
                    end
                end else if (is_eq && count != '0) begin
                    chain_next = 1'b0;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op == OP_DIV) begin
                    if (acc == '0) begin
                        result_next = '0;
                        state_next  = S_ERR;
                    end else begin
                        div_rem_next = '0;
                        div_quo_next = a_mag;
                        div_den_next = acc;
                        div_cnt_next = '0;
                        div_neg_next = a_reg[WIDTH-1];
                        state_next   = S_DIV;
                    end
                end else if (!wide_fits) begin
                    result_next = '0;
                    state_next  = S_ERR;
                end else begin
                    complete       = 1'b1;
                    complete_value = wide[WIDTH-1:0];
                end
            end
            S_DIV: begin
                div_rem_next = div_rem_step;
                div_quo_next = div_quo_step;
                div_cnt_next = div_cnt + NW'(1);
                if (div_cnt == DIV_LAST) begin
                    complete       = 1'b1;
                    complete_value = div_value;
                end
            end
            S_DONE: begin
                if (is_digit) begin
                    acc_next   = WIDTH'(digit);
                    count_next = CW'(1);
                    state_next = S_A;
                end else if (is_op) begin
                    a_next     = result_reg;
                    op_next    = key_op;
                    acc_next   = '0;
                    count_next = '0;
                    state_next = S_B;
                end
            end
            S_ERR: ;
            default: state_next = S_A;
        endcase

        if (complete) begin
            result_next = complete_value;
            if (chain) begin
                a_next     = complete_value;
                op_next    = pend_op;
                acc_next   = '0;
                count_next = '0;
                state_next = S_B;
            end else begin
                state_next = S_DONE;
            end
        end

        // Clear outranks everything, including an in-flight computation.
        if (is_clear) begin
            state_next   = S_A;
            op_next      = OP_ADD;
            pend_op_next = OP_ADD;
            chain_next   = 1'b0;
            acc_next     = '0;
            count_next   = '0;
            a_next       = '0;
            result_next  = '0;
            dropped_next = 1'b0;
            div_rem_next = '0;
            div_quo_next = '0;
            div_den_next = '0;
            div_cnt_next = '0;
            div_neg_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_A;
            op         <= OP_ADD;
            pend_op    <= OP_ADD;
            chain      <= 1'b0;
            acc        <= '0;
            count      <= '0;
            a_reg      <= '0;
            result_reg <= '0;
            dropped    <= 1'b0;
            div_rem    <= '0;
            div_quo    <= '0;
            div_den    <= '0;
            div_cnt    <= '0;
            div_neg    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state      <= state_next;
            op         <= op_next;
            pend_op    <= pend_op_next;
            chain      <= chain_next;
            acc        <= acc_next;
            count      <= count_next;
            a_reg      <= a_next;
            result_reg <= result_next;
            dropped    <= dropped_next;
            div_rem    <= div_rem_next;
            div_quo    <= div_quo_next;
            div_den    <= div_den_next;
            div_cnt    <= div_cnt_next;
            div_neg    <= div_neg_next;
        end
    end

    assign operand      = acc;
    assign result       = result_reg;
    assign result_valid = (state == S_DONE);
    assign busy         = (state == S_EXEC) || (state == S_DIV);
    assign error        = (state == S_ERR);
    assign key_dropped  = dropped;

endmodule

// File: tb/tb_multidigit_calculator_fsm.sv
// Directed testbench for multidigit_calculator_fsm (WIDTH=16, MAX_DIGITS=4).
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_multidigit_calculator_fsm;

    localparam logic [7:0] K_CLR = 8'h04;
    localparam logic [7:0] K_ADD = 8'h37;
    localparam logic [7:0] K_SUB = 8'h36;
    localparam logic [7:0] K_MUL = 8'h35;
    localparam logic [7:0] K_DIV = 8'h34;
    localparam logic [7:0] K_EQ  = 8'h24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [7:0]  key_code;
    logic [15:0] operand, result;
    logic        result_valid, busy, error, key_dropped;

    int checks = 0;
    int errors = 0;

    multidigit_calculator_fsm #(.WIDTH(16), .MAX_DIGITS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .operand      (operand),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .error        (error),
        .key_dropped  (key_dropped)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dkey(input int d);
        case (d)
            0: return 8'h14;  1: return 8'h05;  2: return 8'h15;  3: return 8'h25;
            4: return 8'h06;  5: return 8'h16;  6: return 8'h26;  7: return 8'h07;
            8: return 8'h17;  default: return 8'h27;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a falling edge; holds the key for exactly one rising edge.
    task automatic press(input logic [7:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    task automatic type_num(input int n);
        int p;
        p = 1;
        while (p * 10 <= n) p = p * 10;
        while (p > 0) begin
            press(dkey((n / p) % 10));
            p = p / 10;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_valid = 1'b0; key_code = 8'h00;
        repeat (2) tick();
        checks++;
        if ({operand, result, result_valid, busy, error, key_dropped} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got op=%h res=%h rv=%b busy=%b err=%b kd=%b, expected all 0",
                     operand, result, result_valid, busy, error, key_dropped);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        type_num(12);
        checks++; if (operand !== 16'd12) begin errors++; $display("FAIL add_operand_a: got %0d expected 12", operand); end
        press(K_ADD);
        type_num(34);
        checks++; if (operand !== 16'd34) begin errors++; $display("FAIL add_operand_b: got %0d expected 34", operand); end
        press(K_EQ);
        checks++; if (result_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL add_t1: got rv=%b busy=%b expected rv=0 busy=1", result_valid, busy); end
        tick();
        checks++; if (result !== 16'd46 || result_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL add_t2: got res=%0d rv=%b busy=%b expected 46 1 0", result, result_valid, busy); end
    endtask

    task automatic test_sub_div();
        press(K_CLR);
        checks++; if (result !== 16'd0 || result_valid !== 1'b0) begin errors++; $display("FAIL clear_from_done: got res=%h rv=%b expected 0 0", result, result_valid); end
        type_num(5); press(K_SUB); type_num(12); press(K_EQ); tick();
        checks++; if (result !== 16'hFFF9 || result_valid !== 1'b1) begin errors++; $display("FAIL sub_neg: got res=%h rv=%b expected fff9 1", result, result_valid); end
        press(K_DIV); type_num(2); press(K_EQ);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div_exec_busy: got %b expected 1", busy); end
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++; if (busy !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL div_busy_cycle%0d: got busy=%b rv=%b expected 1 0", i, busy, result_valid); end
        end
        tick();
        checks++; if (result !== 16'hFFFD || result_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL div_neg_result: got res=%h rv=%b busy=%b expected fffd 1 0", result, result_valid, busy); end
    endtask

    task automatic test_overflow();
        press(K_CLR);
        type_num(9999); press(K_MUL); type_num(9999); press(K_EQ);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL ovf_t1: got err=%b expected 0", error); end
        tick();
        checks++; if (error !== 1'b1 || result !== 16'd0 || result_valid !== 1'b0) begin errors++; $display("FAIL ovf_err: got err=%b res=%h rv=%b expected 1 0 0", error, result, result_valid); end
        type_num(3);
        checks++; if (error !== 1'b1 || operand !== 16'd9999 || result !== 16'd0) begin errors++; $display("FAIL err_sticky: got err=%b op=%0d res=%h expected 1 9999 0", error, operand, result); end
        press(K_CLR);
        checks++; if (error !== 1'b0 || operand !== 16'd0 || busy !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL err_clear: got err=%b op=%0d busy=%b rv=%b expected 0 0 0 0", error, operand, busy, result_valid); end
        type_num(7);
        checks++; if (operand !== 16'd7) begin errors++; $display("FAIL err_clear_state_a: got op=%0d expected 7", operand); end
    endtask

    task automatic test_div_drop();
        press(K_CLR);
        type_num(100); press(K_DIV); type_num(7); press(K_EQ);
        repeat (3) tick();
        press(dkey(5));
        checks++; if (key_dropped !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b expected 1", key_dropped); end
        tick();
        checks++; if (key_dropped !== 1'b0) begin errors++; $display("FAIL drop_pulse_end: got %b expected 0", key_dropped); end
        repeat (11) tick();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL div_t17: got rv=%b expected 0", result_valid); end
        tick();
        checks++; if (result !== 16'd14 || result_valid !== 1'b1 || operand !== 16'd7) begin errors++; $display("FAIL div_t18: got res=%0d rv=%b op=%0d expected 14 1 7", result, result_valid, operand); end
        type_num(7); press(K_DIV); type_num(0); press(K_EQ); tick();
        checks++; if (error !== 1'b1 || result !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL div_by_zero: got err=%b res=%h busy=%b expected 1 0 0", error, result, busy); end
    endtask

    task automatic test_chain();
        press(K_CLR);
        type_num(2); press(K_ADD); type_num(3); press(K_MUL); tick();
        checks++; if (result !== 16'd5 || result_valid !== 1'b0 || operand !== 16'd0) begin errors++; $display("FAIL chain_mid: got res=%0d rv=%b op=%0d expected 5 0 0", result, result_valid, operand); end
        type_num(4); press(K_EQ); tick();
        checks++; if (result !== 16'd20 || result_valid !== 1'b1) begin errors++; $display("FAIL chain_final: got res=%0d rv=%b expected 20 1", result, result_valid); end
        press(K_ADD); type_num(1); press(K_EQ); tick();
        checks++; if (result !== 16'd21 || result_valid !== 1'b1) begin errors++; $display("FAIL done_continue: got res=%0d rv=%b expected 21 1", result, result_valid); end
        type_num(12345);
        checks++; if (operand !== 16'd1234 || result !== 16'd21 || result_valid !== 1'b0) begin errors++; $display("FAIL digit_limit: got op=%0d res=%0d rv=%b expected 1234 21 0", operand, result, result_valid); end
    endtask

    task automatic test_boundary();
        press(K_CLR);
        type_num(9999); press(K_MUL); type_num(3); press(K_ADD); tick();
        checks++; if (result !== 16'h752D) begin errors++; $display("FAIL bnd_29997: got %h expected 752d", result); end
        type_num(2770); press(K_ADD); tick();
        checks++; if (result !== 16'h7FFF || error !== 1'b0) begin errors++; $display("FAIL bnd_max: got res=%h err=%b expected 7fff 0", result, error); end
        type_num(1); press(K_EQ); tick();
        checks++; if (error !== 1'b1 || result !== 16'd0) begin errors++; $display("FAIL bnd_max_plus1: got err=%b res=%h expected 1 0", error, result); end
        press(K_CLR);
        type_num(0); press(K_SUB); type_num(9999); press(K_MUL); tick();
        checks++; if (result !== 16'hD8F1) begin errors++; $display("FAIL bnd_neg9999: got %h expected d8f1", result); end
        type_num(3); press(K_SUB); tick();
        checks++; if (result !== 16'h8AD3) begin errors++; $display("FAIL bnd_neg29997: got %h expected 8ad3", result); end
        type_num(2771); press(K_EQ); tick();
        checks++; if (result !== 16'h8000 || error !== 1'b0 || result_valid !== 1'b1) begin errors++; $display("FAIL bnd_min: got res=%h err=%b rv=%b expected 8000 0 1", result, error, result_valid); end
        press(K_DIV); type_num(1); press(K_EQ);
        repeat (17) tick();
        checks++; if (result !== 16'h8000 || result_valid !== 1'b1) begin errors++; $display("FAIL bnd_min_div1: got res=%h rv=%b expected 8000 1", result, result_valid); end
        press(K_SUB); type_num(1); press(K_EQ); tick();
        checks++; if (error !== 1'b1 || result !== 16'd0) begin errors++; $display("FAIL bnd_min_minus1: got err=%b res=%h expected 1 0", error, result); end
    endtask

    task automatic test_ignored();
        press(K_CLR);
        type_num(4); press(K_EQ); tick();
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0 || operand !== 16'd4) begin errors++; $display("FAIL eq_in_a: got rv=%b busy=%b op=%0d expected 0 0 4", result_valid, busy, operand); end
        press(K_ADD); press(K_EQ); tick();
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL eq_in_b_empty: got rv=%b busy=%b expected 0 0", result_valid, busy); end
        press(K_SUB); type_num(9); press(K_EQ); tick();
        checks++; if (result !== 16'hFFFB || result_valid !== 1'b1) begin errors++; $display("FAIL op_replace: got res=%h rv=%b expected fffb 1", result, result_valid); end
        press(K_EQ); press(8'hFF); tick();
        checks++; if (result !== 16'hFFFB || result_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL eq_in_done: got res=%h rv=%b busy=%b expected fffb 1 0", result, result_valid, busy); end
    endtask

    task automatic test_reset_clear_mid_div();
        press(K_CLR);
        type_num(9); press(K_DIV); type_num(2); press(K_EQ);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({operand, result, result_valid, busy, error, key_dropped} !== 36'd0) begin
            errors++;
            $display("FAIL async_reset_mid_div: got op=%h res=%h rv=%b busy=%b err=%b kd=%b, expected all 0",
                     operand, result, result_valid, busy, error, key_dropped);
        end
        tick();
        rst_n = 1'b1;
        tick();
        type_num(9); press(K_DIV); type_num(2); press(K_EQ);
        repeat (3) tick();
        press(K_CLR);
        checks++; if (busy !== 1'b0 || result !== 16'd0 || result_valid !== 1'b0 || operand !== 16'd0) begin errors++; $display("FAIL clear_mid_div: got busy=%b res=%h rv=%b op=%0d expected 0 0 0 0", busy, result, result_valid, operand); end
        repeat (20) tick();
        checks++; if (result !== 16'd0 || result_valid !== 1'b0) begin errors++; $display("FAIL clear_no_late_update: got res=%h rv=%b expected 0 0", result, result_valid); end
        type_num(6);
        checks++; if (operand !== 16'd6) begin errors++; $display("FAIL clear_mid_div_state_a: got op=%0d expected 6", operand); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_div();
        test_overflow();
        test_div_drop();
        test_chain();
        test_boundary();
        test_ignored();
        test_reset_clear_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
